block_serializer: RTL and testbench
===================================

BLOCK_SERIALIZER -- requirements
Module: block_serializer

Interface
REQ-001 SHALL have parameter N, default 1, giving the maximum number of blocks per input cycle (≥1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the number of block groups buffered (power of two, ≥2).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i, input, N bits: per-lane block valid from the retirement stage.
REQ-006 SHALL have the following input lane arrays, each N lanes wide:
- iretire_i, IRETIRE_LEN per lane
- ilastsize_i, 1 bit per lane
- itype_i, ITYPE_LEN per lane
- cause_i, CAUSE_LEN per lane
- tval_i, XLEN per lane
- priv_i, PRIV_LEN per lane
- iaddr_i, XLEN per lane
REQ-007 SHALL have the following single-block outputs to the trace encoder:
- valid_o, 1 bit
- iretire_o, IRETIRE_LEN
- ilastsize_o, 1 bit
- itype_o, ITYPE_LEN
- cause_o, CAUSE_LEN
- tval_o, XLEN
- priv_o, PRIV_LEN
- iaddr_o, XLEN
REQ-008 SHALL have port ready_i, input, 1 bit: encoder accepts the block when valid_o && ready_i.
REQ-009 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a group was dropped.
REQ-010 SHALL have port clear_overflow_i, input, 1 bit: clears overflow_o and drop_cnt_o.
REQ-011 SHALL have port drop_cnt_o, output, 16 bits: saturating count of dropped groups.

Function
REQ-012 SHALL form a group each cycle any valid_i bit is high: valid lanes are compacted in ascending lane order, and count = popcount(valid_i).
REQ-013 SHALL never push a group in a cycle where valid_i == 0.
REQ-014 SHALL accept a group when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-015 SHALL otherwise drop the whole group (no partial storage), set overflow_o, and increment drop_cnt_o, saturating at 0xFFFF.
REQ-016 SHALL give clear_overflow_i priority over a same-cycle drop: both flags are cleared and the drop is not counted.
REQ-017 SHALL drive valid_o = !fifo_empty, with the payload taken combinationally from slot idx of the FIFO head group.
REQ-018 SHALL present the first block of a group pushed at cycle t no earlier than t+1; with ready_i held high, block k appears at t+1+k.
REQ-019 SHALL keep the payload stable while valid_o && !ready_i; valid_o SHALL not drop without a handshake.
REQ-020 SHALL increment idx on a handshake; when idx == count-1 it SHALL pop the FIFO and reset idx to 0 in the same cycle, with no bubble before the next group.
REQ-021 SHALL implement a two-state FSM: IDLE (FIFO empty, valid_o=0) and EMIT.
- IDLE→EMIT on a push.
- EMIT→IDLE on a last-block handshake with no other group stored or being pushed.
REQ-022 SHALL size idx at $clog2(N) bits (minimum 1) and count at $clog2(N+1) bits; idx SHALL never exceed count-1.
REQ-023 SHALL, when N=1, degenerate to a pass-through FIFO with idx constant at 0.

Reset
REQ-024 SHALL, on rst_ni low and independent of clk_i, put the FIFO empty, idx=0, FSM=IDLE, valid_o=0, overflow_o=0, drop_cnt_o=0, and all payload outputs '0.
REQ-025 SHALL discard any group partially emitted when reset asserts mid-operation; after release, output resumes only with newly pushed groups.

Structure
REQ-026 SHALL take IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, XLEN and PRIV_LEN from mure_pkg.
REQ-027 SHALL define the block struct te_block_s in mure_pkg; the group type (N slots of te_block_s plus count) SHALL be local, since it depends on N.
REQ-028 SHALL instantiate exactly one sub-module: fifo_v3 (dtype = group, DEPTH = FIFO_DEPTH, flush_i and testmode_i tied 0).
REQ-029 SHALL keep idx, the FSM and the overflow logic in this module.

Verification (N=2, FIFO_DEPTH=4)
REQ-030 SHALL cover: valid_i=2'b11, iaddr_i={0x200,0x100}, ready_i=1 → iaddr_o 0x100 at t+1, 0x200 at t+2, valid_o=0 at t+3.
REQ-031 SHALL cover: valid_i=2'b10, iaddr_i[1]=0x80 → a single block with iaddr_o=0x80 at t+1; idx stays 0.
REQ-032 SHALL cover: one 2-block group with ready_i=0 for 5 cycles, then 1 → the first block is held stable for 5 cycles and both blocks are emitted afterwards in order.
REQ-033 SHALL cover: 5 consecutive groups with ready_i=0 → the first 4 are stored, the 5th is dropped, overflow_o=1, drop_cnt_o=1; clear_overflow_i pulse → both return to 0.
REQ-034 SHALL cover: FIFO full and the last block of the head group handshaking while a new group arrives → the new group is accepted and drop_cnt_o is unchanged.
REQ-035 SHALL cover: rst_ni asserted between block 0 and block 1 of a group → valid_o=0 immediately, block 1 is never emitted, and overflow_o=0.

Source files
------------

// File: rtl/mure_pkg.sv
// ============================================================================
// Module      : mure_pkg
// Description : Trace block field widths, block struct and serializer FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IRETIRE_LEN = 7;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } te_block_s;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_EMIT = 1'b1
    } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// ============================================================================
// Module      : fifo_v3
// Description : Synchronous FIFO of arbitrary dtype; accepts a push while full
//               when a pop happens in the same cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_v3 #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic [31:0],
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned CNT_W = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    dtype                  r_mem [DEPTH];
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused;

    assign w_unused = testmode_i;

    assign full_o  = (r_cnt == CNT_W'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign usage_o = r_cnt[ADDR_DEPTH-1:0];
    assign data_o  = r_mem[r_rd_ptr];

    assign w_pop  = pop_i && !empty_o;
    // When full, the slot under the write pointer is the one being popped.
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + ADDR_DEPTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_DEPTH'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/block_serializer.sv
// ============================================================================
// Module      : block_serializer
// Description : Compacts up to N retired blocks per cycle into groups, buffers
//               them and emits one block per handshake to the trace encoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module block_serializer
    import mure_pkg::*;
#(
    parameter int unsigned N          = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N-1:0]                    valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0]   iretire_i,
    input  logic [N-1:0]                    ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]     itype_i,
    input  logic [N-1:0][CAUSE_LEN-1:0]     cause_i,
    input  logic [N-1:0][XLEN-1:0]          tval_i,
    input  logic [N-1:0][PRIV_LEN-1:0]      priv_i,
    input  logic [N-1:0][XLEN-1:0]          iaddr_i,
    output logic                            valid_o,
    output logic [IRETIRE_LEN-1:0]          iretire_o,
    output logic                            ilastsize_o,
    output logic [ITYPE_LEN-1:0]            itype_o,
    output logic [CAUSE_LEN-1:0]            cause_o,
    output logic [XLEN-1:0]                 tval_o,
    output logic [PRIV_LEN-1:0]             priv_o,
    output logic [XLEN-1:0]                 iaddr_o,
    input  logic                            ready_i,
    output logic                            overflow_o,
    input  logic                            clear_overflow_i,
    output logic [15:0]                     drop_cnt_o
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        te_block_s [N-1:0]  blocks;
        logic [CNT_W-1:0]   count;
    } group_t;

    group_t             w_in_grp;
    group_t             w_head;
    te_block_s          w_blk;
    logic               w_full;
    logic               w_empty;
    logic [PTR_W-1:0]   w_usage;
    logic               w_push_req;
    logic               w_accept;
    logic               w_drop;
    logic               w_hs;
    logic               w_last;
    logic               w_pop;
    logic [IDX_W-1:0]   r_idx;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;
    ser_state_e         r_state;
    ser_state_e         w_state_nxt;

    // Lane i lands in slot popcount(valid_i[i-1:0]).
    always_comb begin
        logic [CNT_W-1:0] pos;
        te_block_s        lane;
        w_in_grp = '0;
        pos      = '0;
        for (int i = 0; i < int'(N); i++) begin
            lane = '{iretire:   iretire_i[i],
                     ilastsize: ilastsize_i[i],
                     itype:     itype_i[i],
                     cause:     cause_i[i],
                     tval:      tval_i[i],
                     priv:      priv_i[i],
                     iaddr:     iaddr_i[i]};
            if (valid_i[i]) begin
                for (int s = 0; s < int'(N); s++) begin
                    if (pos == CNT_W'(s)) begin
                        w_in_grp.blocks[s] = lane;
                    end
                end
                pos = pos + CNT_W'(1);
            end
        end
        w_in_grp.count = pos;
    end

    assign w_push_req = |valid_i;
    assign w_hs       = valid_o && ready_i;
    assign w_last     = ((CNT_W'(r_idx) + CNT_W'(1)) == w_head.count);
    assign w_pop      = w_hs && w_last;
    assign w_accept   = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_accept;

    fifo_v3 #(
        .DEPTH (FIFO_DEPTH),
        .dtype (group_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .usage_o    (w_usage),
        .data_i     (w_in_grp),
        .push_i     (w_accept),
        .data_o     (w_head),
        .pop_i      (w_pop)
    );

    always_comb begin
        w_blk = '0;
        if (!w_empty) begin
            for (int s = 0; s < int'(N); s++) begin
                if (r_idx == IDX_W'(s)) begin
                    w_blk = w_head.blocks[s];
                end
            end
        end
    end

    assign valid_o     = !w_empty;
    assign iretire_o   = w_blk.iretire;
    assign ilastsize_o = w_blk.ilastsize;
    assign itype_o     = w_blk.itype;
    assign cause_o     = w_blk.cause;
    assign tval_o      = w_blk.tval;
    assign priv_o      = w_blk.priv;
    assign iaddr_o     = w_blk.iaddr;
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Another group remains when the FIFO holds more than the one being popped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SER_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SER_EMIT;
                end
            end
            SER_EMIT: begin
                if (w_pop && !w_accept && !w_full && (w_usage == PTR_W'(1))) begin
                    w_state_nxt = SER_IDLE;
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_overflow_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_serializer.sv
// ============================================================================
// Module      : tb_block_serializer
// Description : Directed self-checking bench for block_serializer (N=2, depth 4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_block_serializer;
    import mure_pkg::*;

    localparam int unsigned N = 2;

    logic                          clk_i;
    logic                          rst_ni;
    logic [N-1:0]                  valid_i;
    logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0]                  ilastsize_i;
    logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
    logic [N-1:0][CAUSE_LEN-1:0]   cause_i;
    logic [N-1:0][XLEN-1:0]        tval_i;
    logic [N-1:0][PRIV_LEN-1:0]    priv_i;
    logic [N-1:0][XLEN-1:0]        iaddr_i;
    logic                          valid_o;
    logic [IRETIRE_LEN-1:0]        iretire_o;
    logic                          ilastsize_o;
    logic [ITYPE_LEN-1:0]          itype_o;
    logic [CAUSE_LEN-1:0]          cause_o;
    logic [XLEN-1:0]               tval_o;
    logic [PRIV_LEN-1:0]           priv_o;
    logic [XLEN-1:0]               iaddr_o;
    logic                          ready_i;
    logic                          overflow_o;
    logic                          clear_overflow_i;
    logic [15:0]                   drop_cnt_o;

    int n_checks;
    int n_fail;

    block_serializer #(
        .N          (N),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .valid_i          (valid_i),
        .iretire_i        (iretire_i),
        .ilastsize_i      (ilastsize_i),
        .itype_i          (itype_i),
        .cause_i          (cause_i),
        .tval_i           (tval_i),
        .priv_i           (priv_i),
        .iaddr_i          (iaddr_i),
        .valid_o          (valid_o),
        .iretire_o        (iretire_o),
        .ilastsize_o      (ilastsize_o),
        .itype_o          (itype_o),
        .cause_o          (cause_o),
        .tval_o           (tval_o),
        .priv_o           (priv_o),
        .iaddr_o          (iaddr_o),
        .ready_i          (ready_i),
        .overflow_o       (overflow_o),
        .clear_overflow_i (clear_overflow_i),
        .drop_cnt_o       (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_group(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        valid_i    = v;
        iaddr_i[0] = a0;
        iaddr_i[1] = a1;
        tval_i[0]  = a0 + 32'd4;
        tval_i[1]  = a1 + 32'd4;
    endtask

    task automatic expect_blk(input string tag, input logic [31:0] addr);
        check({tag, "_valid"}, valid_o, 1'b1);
        check({tag, "_iaddr"}, iaddr_o, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_ni           = 1'b0;
        ready_i          = 1'b0;
        clear_overflow_i = 1'b0;
        valid_i          = '0;
        iaddr_i          = '0;
        tval_i           = '0;
        iretire_i[0] = 7'd3;  iretire_i[1] = 7'd4;
        itype_i[0]   = 3'd1;  itype_i[1]   = 3'd2;
        cause_i[0]   = 5'd10; cause_i[1]   = 5'd11;
        priv_i[0]    = 2'd1;  priv_i[1]    = 2'd2;
        ilastsize_i  = 2'b10;

        repeat (2) @(negedge clk_i);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_drop", drop_cnt_o, 16'd0);
        check("rst_iaddr", iaddr_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Two-lane group drained back to back.
        ready_i = 1'b1;
        set_group(2'b11, 32'h100, 32'h200);
        @(negedge clk_i);
        valid_i = '0;
        expect_blk("g11_b0", 32'h100);
        check("g11_b0_priv", priv_o, 2'd1);
        check("g11_b0_cause", cause_o, 5'd10);
        @(negedge clk_i);
        expect_blk("g11_b1", 32'h200);
        check("g11_b1_iret", iretire_o, 7'd4);
        check("g11_b1_lsz", ilastsize_o, 1'b1);
        @(negedge clk_i);
        check("g11_done", valid_o, 1'b0);

        // Only lane 1 valid: compacts into slot 0.
        set_group(2'b10, 32'hDEAD, 32'h80);
        @(negedge clk_i);
        valid_i = '0;
        expect_blk("g10", 32'h80);
        check("g10_tval", tval_o, 32'h84);
        check("g10_priv", priv_o, 2'd2);
        check("g10_itype", itype_o, 3'd2);
        check("g10_idx", dut.r_idx, 1'b0);
        @(negedge clk_i);
        check("g10_done", valid_o, 1'b0);

        // Backpressure holds block 0 stable.
        ready_i = 1'b0;
        set_group(2'b11, 32'h300, 32'h340);
        @(negedge clk_i);
        valid_i = '0;
        for (int i = 0; i < 5; i++) begin
            expect_blk("hold_b0", 32'h300);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        expect_blk("rel_b0", 32'h300);
        @(negedge clk_i);
        expect_blk("rel_b1", 32'h340);
        @(negedge clk_i);
        check("rel_done", valid_o, 1'b0);

        // Five single-block groups without draining: the fifth is dropped.
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_group(2'b01, 32'h400 + 32'(i) * 32'h10, 32'h0);
            @(negedge clk_i);
        end
        valid_i = '0;
        check("ovf_set", overflow_o, 1'b1);
        check("ovf_cnt", drop_cnt_o, 16'd1);
        expect_blk("ovf_head", 32'h400);
        clear_overflow_i = 1'b1;
        @(negedge clk_i);
        clear_overflow_i = 1'b0;
        check("ovf_clr", overflow_o, 1'b0);
        check("ovf_cnt_clr", drop_cnt_o, 16'd0);

        // Full FIFO: head pops while a new group arrives; nothing is dropped.
        set_group(2'b11, 32'h450, 32'h460);
        ready_i = 1'b1;
        expect_blk("full_head", 32'h400);
        @(negedge clk_i);
        valid_i = '0;
        check("full_ovf", overflow_o, 1'b0);
        check("full_cnt", drop_cnt_o, 16'd0);
        expect_blk("drain0", 32'h410);
        @(negedge clk_i);
        expect_blk("drain1", 32'h420);
        @(negedge clk_i);
        expect_blk("drain2", 32'h430);
        @(negedge clk_i);
        expect_blk("drain3", 32'h450);
        @(negedge clk_i);
        expect_blk("drain4", 32'h460);
        @(negedge clk_i);
        check("drain_done", valid_o, 1'b0);

        // Reset between block 0 and block 1.
        set_group(2'b11, 32'h500, 32'h580);
        @(negedge clk_i);
        valid_i = '0;
        expect_blk("rstm_b0", 32'h500);
        rst_ni = 1'b0;
        #1;
        check("rstm_valid", valid_o, 1'b0);
        check("rstm_iaddr", iaddr_o, 32'd0);
        check("rstm_ovf", overflow_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rstm_idle", valid_o, 1'b0);
        end
        set_group(2'b01, 32'h600, 32'h0);
        @(negedge clk_i);
        valid_i = '0;
        expect_blk("post_rst", 32'h600);
        @(negedge clk_i);
        check("post_rst_done", valid_o, 1'b0);
        check("post_rst_ovf", overflow_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
